ram_bus_arbiter: RTL and testbench

- Two-master arbiter and transaction sequencer for the shared 8-bit memory bus (BUS_ADDR / BUS_DATA / BUS_WE).
- The bus is served by the 128x8 data RAM at 0x00-0x7F and by memory-mapped peripherals.
- Each master issues single-byte read or write requests through a REQ/ACK handshake.
- The block grants the bus round-robin, drives the bus for the granted master, sequences the RAM's one-cycle registered read latency, and returns read data.

---
 rtl/ram_bus_arbiter_if.sv | 33 +++
 rtl/ram_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ram_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bus_arbiter_if.sv
// Request/acknowledge bundle between the two bus masters and ram_bus_arbiter.
// Each master owns one REQ/WE/ADDR/WDATA group and receives one ACK/RDATA pair.
interface ram_bus_arbiter_if;
    logic       M0_REQ;
    logic       M0_WE;
    logic [7:0] M0_ADDR;
    logic [7:0] M0_WDATA;
    logic       M0_ACK;
    logic [7:0] M0_RDATA;

    logic       M1_REQ;
    logic       M1_WE;
    logic [7:0] M1_ADDR;
    logic [7:0] M1_WDATA;
    logic       M1_ACK;
    logic [7:0] M1_RDATA;

    // Requesting side: drives the request fields, observes completion
    modport master (
        output M0_REQ, M0_WE, M0_ADDR, M0_WDATA,
        input  M0_ACK, M0_RDATA,
        output M1_REQ, M1_WE, M1_ADDR, M1_WDATA,
        input  M1_ACK, M1_RDATA
    );

    // Arbiter side: samples requests, returns completion and read data
    modport slave (
        input  M0_REQ, M0_WE, M0_ADDR, M0_WDATA,
        output M0_ACK, M0_RDATA,
        input  M1_REQ, M1_WE, M1_ADDR, M1_WDATA,
        output M1_ACK, M1_RDATA
    );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared 8-bit memory bus.
// Every output is a register loaded from the next-state decode, so no M*_ input reaches the bus combinationally.
module ram_bus_arbiter #(
    parameter logic [7:0] IDLE_ADDR = 8'hFF
) (
    input  logic             CLK,
    input  logic             RESET,
    ram_bus_arbiter_if.slave mif,
    output logic [7:0]       BUS_ADDR,
    inout  wire  [7:0]       BUS_DATA,
    output logic             BUS_WE,
    output logic             BUSY
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_RD_ADDR = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;

    logic [2:0] state_r;
    logic       sel_r;
    logic [7:0] addr_r;
    logic [7:0] wdata_r;
    logic       last_r;
    logic [7:0] bus_addr_r;
    logic       bus_we_r;
    logic       busy_r;
    logic       m0_ack_r;
    logic       m1_ack_r;
    logic [7:0] m0_rdata_r;
    logic [7:0] m1_rdata_r;

    logic       grant_any_s;
    logic       grant_sel_s;
    logic       grant_we_s;
    logic [7:0] grant_addr_s;
    logic [7:0] grant_wdata_s;

    logic [2:0] state_nx_s;
    logic       sel_nx_s;
    logic [7:0] addr_nx_s;
    logic [7:0] wdata_nx_s;
    logic       last_nx_s;
    logic [7:0] m0_rdata_nx_s;
    logic [7:0] m1_rdata_nx_s;

    logic       bus_active_s;
    logic [7:0] bus_addr_nx_s;
    logic       bus_we_nx_s;
    logic       busy_nx_s;
    logic       m0_ack_nx_s;
    logic       m1_ack_nx_s;

    // Round-robin pick: a lone requester wins, a tie goes to the master not served last
    always_comb begin
        grant_any_s = mif.M0_REQ | mif.M1_REQ;
        if (mif.M0_REQ && mif.M1_REQ) begin
            grant_sel_s = ~last_r;
        end else if (mif.M1_REQ) begin
            grant_sel_s = 1'b1;
        end else begin
            grant_sel_s = 1'b0;
        end
        if (grant_sel_s) begin
            grant_we_s    = mif.M1_WE;
            grant_addr_s  = mif.M1_ADDR;
            grant_wdata_s = mif.M1_WDATA;
        end else begin
            grant_we_s    = mif.M0_WE;
            grant_addr_s  = mif.M0_ADDR;
            grant_wdata_s = mif.M0_WDATA;
        end
    end

    // Transaction sequencer: next state, latched request and captured read data
    always_comb begin
        state_nx_s    = state_r;
        sel_nx_s      = sel_r;
        addr_nx_s     = addr_r;
        wdata_nx_s    = wdata_r;
        last_nx_s     = last_r;
        m0_rdata_nx_s = m0_rdata_r;
        m1_rdata_nx_s = m1_rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_any_s) begin
                    sel_nx_s   = grant_sel_s;
                    addr_nx_s  = grant_addr_s;
                    wdata_nx_s = grant_wdata_s;
                    last_nx_s  = grant_sel_s;
                    state_nx_s = grant_we_s ? ST_WR : ST_RD_ADDR;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WR: begin
                state_nx_s = ST_ACK;
            end
            ST_RD_ADDR: begin
                state_nx_s = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // The RAM's registered output is valid on the bus throughout this cycle
                if (sel_r) begin
                    m1_rdata_nx_s = BUS_DATA;
                end else begin
                    m0_rdata_nx_s = BUS_DATA;
                end
                state_nx_s = ST_ACK;
            end
            ST_ACK: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Bus and handshake outputs decoded from the state being entered
    always_comb begin
        bus_active_s  = (state_nx_s == ST_WR) || (state_nx_s == ST_RD_ADDR) ||
                        (state_nx_s == ST_RD_DATA);
        bus_addr_nx_s = bus_active_s ? addr_nx_s : IDLE_ADDR;
        bus_we_nx_s   = (state_nx_s == ST_WR);
        busy_nx_s     = (state_nx_s != ST_IDLE);
        m0_ack_nx_s   = (state_nx_s == ST_ACK) && !sel_nx_s;
        m1_ack_nx_s   = (state_nx_s == ST_ACK) && sel_nx_s;
    end

    // State and output registers; reset aborts any transaction and releases the bus at once
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r    <= ST_IDLE;
            sel_r      <= 1'b0;
            addr_r     <= 8'h00;
            wdata_r    <= 8'h00;
            last_r     <= 1'b1;
            bus_addr_r <= IDLE_ADDR;
            bus_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            m0_ack_r   <= 1'b0;
            m1_ack_r   <= 1'b0;
            m0_rdata_r <= 8'h00;
            m1_rdata_r <= 8'h00;
        end else begin
            state_r    <= state_nx_s;
            sel_r      <= sel_nx_s;
            addr_r     <= addr_nx_s;
            wdata_r    <= wdata_nx_s;
            last_r     <= last_nx_s;
            bus_addr_r <= bus_addr_nx_s;
            bus_we_r   <= bus_we_nx_s;
            busy_r     <= busy_nx_s;
            m0_ack_r   <= m0_ack_nx_s;
            m1_ack_r   <= m1_ack_nx_s;
            m0_rdata_r <= m0_rdata_nx_s;
            m1_rdata_r <= m1_rdata_nx_s;
        end
    end

    // The data driver is enabled exactly during the write phase
    assign BUS_DATA     = bus_we_r ? wdata_r : 8'hzz;
    assign BUS_ADDR     = bus_addr_r;
    assign BUS_WE       = bus_we_r;
    assign BUSY         = busy_r;
    assign mif.M0_ACK   = m0_ack_r;
    assign mif.M1_ACK   = m1_ack_r;
    assign mif.M0_RDATA = m0_rdata_r;
    assign mif.M1_RDATA = m1_rdata_r;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter with a 128x8 registered-read RAM model on the shared bus.
// A pull-up on BUS_DATA makes a released bus read as 8'hFF.
module tb_ram_bus_arbiter;
    logic       CLK;
    logic       RESET;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic       busy;
    wire  [7:0] bus_data;

    int n_cmp = 0;
    int n_bad = 0;
    int clash_cnt = 0;

    ram_bus_arbiter_if mif();

    ram_bus_arbiter #(.IDLE_ADDR(8'hFF)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .mif      (mif),
        .BUS_ADDR (bus_addr),
        .BUS_DATA (bus_data),
        .BUS_WE   (bus_we),
        .BUSY     (busy)
    );

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus_data[g]);
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM model: 0x00-0x7F, write on the closing edge, one-cycle registered read
    logic [7:0] mem [0:127];
    logic       ram_oe_r;
    logic [7:0] ram_q_r;
    logic       pl_en;
    logic [6:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge CLK) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus_we === 1'b1 && bus_addr[7] == 1'b0) mem[bus_addr[6:0]] <= bus_data;
        ram_oe_r <= (bus_we === 1'b0) && (bus_addr[7] == 1'b0);
        ram_q_r  <= mem[bus_addr[6:0]];
    end
    assign bus_data = (ram_oe_r === 1'b1) ? ram_q_r : 8'hzz;

    always @(negedge CLK) begin
        if (bus_we === 1'b1 && ram_oe_r === 1'b1) clash_cnt <= clash_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        mif.M0_REQ = req; mif.M0_WE = we; mif.M0_ADDR = addr; mif.M0_WDATA = wdata;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        mif.M1_REQ = req; mif.M1_WE = we; mif.M1_ADDR = addr; mif.M1_WDATA = wdata;
    endtask

    // Steps until the chosen master's ACK is seen; lat = -1 when the budget runs out
    task automatic run_to_ack(input logic m, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if ((m == 1'b0 && mif.M0_ACK === 1'b1) || (m == 1'b1 && mif.M1_ACK === 1'b1)) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        RESET = 1'b0;
        set_m0(1'b1, 1'b0, 8'h00, 8'h00);
        set_m1(1'b1, 1'b0, 8'h7F, 8'h00);
        repeat (3) step();
        n_cmp++; if (bus_addr !== 8'hFF) begin n_bad++; $display("FAIL reset_bus_addr got %h want ff", bus_addr); end
        n_cmp++; if (bus_we !== 1'b0) begin n_bad++; $display("FAIL reset_bus_we got %b want 0", bus_we); end
        n_cmp++; if (bus_data !== 8'hFF) begin n_bad++; $display("FAIL reset_bus_released got %h want ff", bus_data); end
        n_cmp++; if (mif.M0_ACK !== 1'b0 || mif.M1_ACK !== 1'b0) begin n_bad++; $display("FAIL reset_acks got %b%b want 00", mif.M0_ACK, mif.M1_ACK); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (mif.M0_RDATA !== 8'h00 || mif.M1_RDATA !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got %h/%h want 00/00", mif.M0_RDATA, mif.M1_RDATA); end
        RESET = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b1 || bus_addr !== 8'h00) begin n_bad++; $display("FAIL reset_first_grant got busy=%b addr=%h want busy=1 addr=00", busy, bus_addr); end
        run_to_ack(1'b0, 10, lat);
        n_cmp++; if (lat !== 2 || mif.M0_RDATA !== 8'hC3) begin n_bad++; $display("FAIL reset_m0_read got lat=%0d data=%h want lat=2 data=c3", lat, mif.M0_RDATA); end
        set_m0(1'b0, 1'b0, 8'h00, 8'h00);
        run_to_ack(1'b1, 12, lat);
        n_cmp++; if (lat !== 4 || mif.M1_RDATA !== 8'h3C) begin n_bad++; $display("FAIL reset_m1_deferred got lat=%0d data=%h want lat=4 data=3c", lat, mif.M1_RDATA); end
        n_cmp++; if (mif.M0_RDATA !== 8'hC3) begin n_bad++; $display("FAIL reset_m0_rdata_held got %h want c3", mif.M0_RDATA); end
        set_m1(1'b0, 1'b0, 8'h00, 8'h00);
        step();
    endtask

    task automatic test_tie();
        int grants [4];
        int g;
        int lat;
        logic m0_rearm;
        logic m1_rearm;
        for (int k = 0; k < 4; k++) grants[k] = -1;
        g = 0; m0_rearm = 1'b0; m1_rearm = 1'b0;
        set_m0(1'b1, 1'b1, 8'h20, 8'h01);
        set_m1(1'b1, 1'b1, 8'h21, 8'h02);
        for (int i = 0; i < 60 && g < 4; i++) begin
            step();
            if (m0_rearm) begin mif.M0_REQ = 1'b1; m0_rearm = 1'b0; end
            if (m1_rearm) begin mif.M1_REQ = 1'b1; m1_rearm = 1'b0; end
            if (mif.M0_ACK === 1'b1) begin grants[g] = 0; g++; mif.M0_REQ = 1'b0; m0_rearm = 1'b1; end
            if (mif.M1_ACK === 1'b1 && g < 4) begin grants[g] = 1; g++; mif.M1_REQ = 1'b0; m1_rearm = 1'b1; end
        end
        set_m0(1'b0, 1'b0, 8'h00, 8'h00);
        set_m1(1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (grants[k] !== k % 2) begin n_bad++; $display("FAIL tie_grant_%0d got %0d want %0d", k, grants[k], k % 2); end
        end
        step();
        set_m0(1'b1, 1'b0, 8'h20, 8'h00);
        run_to_ack(1'b0, 10, lat);
        n_cmp++; if (lat !== 3 || mif.M0_RDATA !== 8'h01) begin n_bad++; $display("FAIL tie_readback_m0 got lat=%0d data=%h want lat=3 data=01", lat, mif.M0_RDATA); end
        set_m0(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        set_m1(1'b1, 1'b0, 8'h21, 8'h00);
        run_to_ack(1'b1, 10, lat);
        n_cmp++; if (lat !== 3 || mif.M1_RDATA !== 8'h02) begin n_bad++; $display("FAIL tie_readback_m1 got lat=%0d data=%h want lat=3 data=02", lat, mif.M1_RDATA); end
        n_cmp++; if (mif.M0_RDATA !== 8'h01) begin n_bad++; $display("FAIL tie_m0_rdata_held got %h want 01", mif.M0_RDATA); end
        set_m1(1'b0, 1'b0, 8'h00, 8'h00);
        step();
    endtask

    task automatic test_boundary();
        int lat;
        set_m0(1'b1, 1'b1, 8'h80, 8'h5A);
        run_to_ack(1'b0, 10, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL bound_write_80_latency got %0d want 2", lat); end
        set_m0(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        set_m0(1'b1, 1'b0, 8'h00, 8'h00);
        run_to_ack(1'b0, 10, lat);
        n_cmp++; if (lat !== 3 || mif.M0_RDATA !== 8'hC3) begin n_bad++; $display("FAIL bound_read_00 got lat=%0d data=%h want lat=3 data=c3", lat, mif.M0_RDATA); end
        set_m0(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        set_m1(1'b1, 1'b0, 8'h7F, 8'h00);
        run_to_ack(1'b1, 10, lat);
        n_cmp++; if (lat !== 3 || mif.M1_RDATA !== 8'h3C) begin n_bad++; $display("FAIL bound_read_7f got lat=%0d data=%h want lat=3 data=3c", lat, mif.M1_RDATA); end
        set_m1(1'b0, 1'b0, 8'h00, 8'h00);
        step();
    endtask

    task automatic test_mixed();
        int order [2];
        int n_done;
        int clash0;
        int lat;
        logic seen_wr;
        order[0] = -1; order[1] = -1; n_done = 0; seen_wr = 1'b0;
        clash0 = clash_cnt;
        set_m0(1'b1, 1'b0, 8'h7F, 8'h00);
        set_m1(1'b1, 1'b1, 8'h7F, 8'h55);
        for (int i = 0; i < 30 && n_done < 2; i++) begin
            step();
            if (bus_we === 1'b1 && !seen_wr) begin
                seen_wr = 1'b1;
                n_cmp++; if (bus_addr !== 8'h7F || bus_data !== 8'h55) begin n_bad++; $display("FAIL mixed_write_phase got addr=%h data=%h want 7f/55", bus_addr, bus_data); end
            end
            if (mif.M0_ACK === 1'b1) begin order[n_done] = 0; n_done++; mif.M0_REQ = 1'b0; end
            if (mif.M1_ACK === 1'b1 && n_done < 2) begin order[n_done] = 1; n_done++; mif.M1_REQ = 1'b0; end
        end
        set_m0(1'b0, 1'b0, 8'h00, 8'h00);
        set_m1(1'b0, 1'b0, 8'h00, 8'h00);
        n_cmp++; if (order[0] !== 0 || order[1] !== 1) begin n_bad++; $display("FAIL mixed_order got %0d,%0d want 0,1", order[0], order[1]); end
        n_cmp++; if (mif.M0_RDATA !== 8'h3C) begin n_bad++; $display("FAIL mixed_m0_read got %h want 3c", mif.M0_RDATA); end
        n_cmp++; if (mif.M1_RDATA !== 8'h3C) begin n_bad++; $display("FAIL mixed_m1_rdata_held got %h want 3c", mif.M1_RDATA); end
        n_cmp++; if (clash_cnt - clash0 !== 0) begin n_bad++; $display("FAIL mixed_bus_contention got %0d cycles want 0", clash_cnt - clash0); end
        step();
        set_m1(1'b1, 1'b0, 8'h7F, 8'h00);
        run_to_ack(1'b1, 10, lat);
        n_cmp++; if (lat !== 3 || mif.M1_RDATA !== 8'h55) begin n_bad++; $display("FAIL mixed_readback got lat=%0d data=%h want lat=3 data=55", lat, mif.M1_RDATA); end
        set_m1(1'b0, 1'b0, 8'h00, 8'h00);
        step();
    endtask

    task automatic test_write_read();
        set_m0(1'b1, 1'b1, 8'h10, 8'hA5);
        step();
        n_cmp++; if (bus_we !== 1'b1 || bus_addr !== 8'h10 || bus_data !== 8'hA5) begin n_bad++; $display("FAIL wr_phase got we=%b addr=%h data=%h want 1/10/a5", bus_we, bus_addr, bus_data); end
        n_cmp++; if (mif.M0_ACK !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL wr_early_ack got ack=%b busy=%b want 0/1", mif.M0_ACK, busy); end
        step();
        n_cmp++; if (mif.M0_ACK !== 1'b1 || mif.M1_ACK !== 1'b0) begin n_bad++; $display("FAIL wr_ack got m0=%b m1=%b want 1/0", mif.M0_ACK, mif.M1_ACK); end
        n_cmp++; if (bus_we !== 1'b0 || bus_addr !== 8'hFF) begin n_bad++; $display("FAIL wr_ack_bus got we=%b addr=%h want 0/ff", bus_we, bus_addr); end
        set_m0(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        n_cmp++; if (busy !== 1'b0 || mif.M0_ACK !== 1'b0 || bus_we !== 1'b0) begin n_bad++; $display("FAIL wr_idle got busy=%b ack=%b we=%b want 0/0/0", busy, mif.M0_ACK, bus_we); end
        set_m0(1'b1, 1'b0, 8'h10, 8'h00);
        step();
        n_cmp++; if (bus_addr !== 8'h10 || bus_we !== 1'b0) begin n_bad++; $display("FAIL rd_addr_phase got addr=%h we=%b want 10/0", bus_addr, bus_we); end
        step();
        n_cmp++; if (mif.M0_ACK !== 1'b0 || bus_addr !== 8'h10) begin n_bad++; $display("FAIL rd_data_phase got ack=%b addr=%h want 0/10", mif.M0_ACK, bus_addr); end
        step();
        n_cmp++; if (mif.M0_ACK !== 1'b1 || mif.M0_RDATA !== 8'hA5) begin n_bad++; $display("FAIL rd_ack got ack=%b data=%h want 1/a5", mif.M0_ACK, mif.M0_RDATA); end
        set_m0(1'b0, 1'b0, 8'h00, 8'h00);
        step();
    endtask

    task automatic test_reset_mid_read();
        int acks;
        int lat;
        acks = 0;
        set_m1(1'b1, 1'b0, 8'h00, 8'h00);
        step();
        step();
        n_cmp++; if (bus_addr !== 8'h00 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_rd_setup got addr=%h busy=%b want 00/1", bus_addr, busy); end
        RESET = 1'b0;
        #1;
        n_cmp++; if (bus_addr !== 8'hFF || bus_we !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_outputs got addr=%h we=%b busy=%b want ff/0/0", bus_addr, bus_we, busy); end
        n_cmp++; if (mif.M1_RDATA !== 8'h00 || mif.M0_RDATA !== 8'h00) begin n_bad++; $display("FAIL mid_rst_rdata got %h/%h want 00/00", mif.M0_RDATA, mif.M1_RDATA); end
        set_m1(1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            if (mif.M0_ACK !== 1'b0 || mif.M1_ACK !== 1'b0) acks++;
            step();
        end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL mid_rst_no_ack got %0d ack cycles want 0", acks); end
        n_cmp++; if (bus_data !== 8'hFF) begin n_bad++; $display("FAIL mid_rst_bus_released got %h want ff", bus_data); end
        RESET = 1'b1;
        step();
        set_m1(1'b1, 1'b0, 8'h10, 8'h00);
        run_to_ack(1'b1, 10, lat);
        n_cmp++; if (lat !== 3 || mif.M1_RDATA !== 8'hA5) begin n_bad++; $display("FAIL mid_rst_recover got lat=%0d data=%h want lat=3 data=a5", lat, mif.M1_RDATA); end
        set_m1(1'b0, 1'b0, 8'h00, 8'h00);
        step();
    endtask

    initial begin
        RESET = 1'b0;
        pl_en = 1'b0; pl_addr = 7'h00; pl_data = 8'h00;
        set_m0(1'b0, 1'b0, 8'h00, 8'h00);
        set_m1(1'b0, 1'b0, 8'h00, 8'h00);
        pl_en = 1'b1; pl_addr = 7'h00; pl_data = 8'hC3;
        step();
        pl_addr = 7'h7F; pl_data = 8'h3C;
        step();
        pl_en = 1'b0;
        test_reset();
        test_tie();
        test_boundary();
        test_mixed();
        test_write_read();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
